// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the universal shift register and its shift counter.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    HOLD        = 2'd0,
    SHIFT_RIGHT = 2'd1,
    SHIFT_LEFT  = 2'd2,
    LOAD        = 2'd3
  } mode_t;

  function automatic int count_width(int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_counter.sv
// Counts shifts since the last load, saturating at WIDTH, with empty and done flags.
module shift_counter
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            load,
  input  logic                            shift,
  output logic [count_width(WIDTH)-1:0]   shift_count,
  output logic                            empty,
  output logic                            done
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_p0;
  logic          empty_p0;
  logic          done_p0;

  // count/flag register stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_p0 <= '0;
      empty_p0 <= 1'b1;
      done_p0  <= 1'b0;
    end else if (load) begin
      count_p0 <= '0;
      empty_p0 <= 1'b0;
      done_p0  <= 1'b0;
    end else if (shift && (count_p0 != FULL)) begin
      count_p0 <= count_p0 + CW'(1);
      if (count_p0 == LAST) begin
        empty_p0 <= 1'b1;
        done_p0  <= 1'b1;
      end else begin
        done_p0  <= 1'b0;
      end
    end else begin
      done_p0 <= 1'b0;
    end
  end

  assign shift_count = count_p0;
  assign empty       = empty_p0;
  assign done        = done_p0;

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register (hold/shift right/shift left/load) with shift counter.
// Optional macro USR_ROTATE_EN adds a rotate input that recirculates the shifted-out bit.
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [1:0]                      mode,
  input  logic [WIDTH-1:0]                parallel_in,
  input  logic                            serial_in_msb,
  input  logic                            serial_in_lsb,
`ifdef USR_ROTATE_EN
  input  logic                            rotate,
`endif
  output logic [WIDTH-1:0]                parallel_out,
  output logic                            serial_out_lsb,
  output logic                            serial_out_msb,
  output logic [count_width(WIDTH)-1:0]   shift_count,
  output logic                            empty,
  output logic                            done
);

  mode_t            mode_e;
  logic [WIDTH-1:0] data_p0;
  logic [WIDTH-1:0] data_next;
  logic             fill_msb;
  logic             fill_lsb;
  logic             do_load;
  logic             do_shift;

  assign mode_e = mode_t'(mode);

`ifdef USR_ROTATE_EN
  assign fill_msb = rotate ? data_p0[0]       : serial_in_msb;
  assign fill_lsb = rotate ? data_p0[WIDTH-1] : serial_in_lsb;
`else
  assign fill_msb = serial_in_msb;
  assign fill_lsb = serial_in_lsb;
`endif

  // An unknown mode matches no item and falls through to hold.
  always_comb begin
    data_next = data_p0;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    case (mode_e)
      SHIFT_RIGHT: begin
        data_next = {fill_msb, data_p0[WIDTH-1:1]};
        do_shift  = 1'b1;
      end
      SHIFT_LEFT: begin
        data_next = {data_p0[WIDTH-2:0], fill_lsb};
        do_shift  = 1'b1;
      end
      LOAD: begin
        data_next = parallel_in;
        do_load   = 1'b1;
      end
      default: ;
    endcase
  end

  // data register stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_p0 <= RESET_VALUE;
    end else begin
      data_p0 <= data_next;
    end
  end

  shift_counter #(
    .WIDTH (WIDTH)
  ) u_shift_counter (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (do_load),
    .shift       (do_shift),
    .shift_count (shift_count),
    .empty       (empty),
    .done        (done)
  );

  assign parallel_out   = data_p0;
  assign serial_out_lsb = data_p0[0];
  assign serial_out_msb = data_p0[WIDTH-1];

`ifndef SYNTHESIS
  mode_known_a: assert property (@(posedge clock) disable iff (!reset_n) !$isunknown(mode));
`endif

endmodule
